// File: rtl/bist_apb_sequencer.sv
// APB requester that sequences runtime BIST runs (start, poll STATUS, fetch signature, clear)
// and reports pass / fail / timeout to the safety monitor.
module bist_apb_sequencer #(
    parameter int unsigned PERIOD         = 1000,
    parameter int unsigned POLL_GAP       = 8,
    parameter int unsigned MAX_POLLS      = 16,
    parameter int unsigned PREADY_TIMEOUT = 64,
    parameter logic [31:0] CTRL_ADDR      = 32'h0000_0000,
    parameter logic [31:0] STATUS_ADDR    = 32'h0000_0004,
    parameter logic [31:0] SIG_ADDR       = 32'h0000_0008
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        trigger_i,
    input  logic        clear_i,
    output logic [31:0] paddr_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    output logic        busy_o,
    output logic        pass_o,
    output logic        fail_o,
    output logic        timeout_o,
    output logic [31:0] last_sig_o,
    output logic [15:0] run_count_o
);

    localparam int unsigned PER_W  = (PERIOD > 1)         ? $clog2(PERIOD)         : 1;
    localparam int unsigned GAP_W  = (POLL_GAP > 1)       ? $clog2(POLL_GAP)       : 1;
    localparam int unsigned POLL_W = (MAX_POLLS > 1)      ? $clog2(MAX_POLLS)      : 1;
    localparam int unsigned WAIT_W = (PREADY_TIMEOUT > 1) ? $clog2(PREADY_TIMEOUT) : 1;

    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(POLL_GAP - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MAX_POLLS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PREADY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_START,
        S_RD_STATUS,
        S_GAP,
        S_RD_SIG,
        S_WR_CLEAR
    } state_t;

    // Sub-phase of a transfer state; PH_IDLE is the mandatory psel=0 cycle before SETUP.
    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_ACCESS
    } phase_t;

    state_t              r_state;
    phase_t              r_phase;
    logic [PER_W-1:0]    r_per_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [POLL_W-1:0]   r_poll_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_err;
    logic [31:0]         r_paddr;
    logic                r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [31:0]         r_pwdata;
    logic                r_busy;
    logic                r_pass;
    logic                r_fail;
    logic                r_timeout;
    logic [31:0]         r_last_sig;
    logic [15:0]         r_run_count;
    logic                w_start;

    function automatic logic [31:0] f_addr(input state_t s);
        case (s)
            S_RD_STATUS: f_addr = STATUS_ADDR;
            S_RD_SIG:    f_addr = SIG_ADDR;
            default:     f_addr = CTRL_ADDR;
        endcase
    endfunction

    // The first IDLE cycle after a run still shows busy, so triggers there are dropped too.
    assign w_start = (r_state == S_IDLE) && !r_busy &&
                     (trigger_i || (enable_i && (r_per_cnt == PER_LAST)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_phase     <= PH_IDLE;
            r_per_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_poll_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
            r_paddr     <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_busy      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_last_sig  <= '0;
            r_run_count <= '0;
        end else begin
            r_pass <= 1'b0;
            if (clear_i) begin
                r_fail    <= 1'b0;
                r_timeout <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (!enable_i || w_start || (r_per_cnt == PER_LAST)) begin
                        r_per_cnt <= '0;
                    end else begin
                        r_per_cnt <= r_per_cnt + 1'b1;
                    end
                    if (w_start) begin
                        r_busy   <= 1'b1;
                        r_state  <= S_WR_START;
                        r_phase  <= PH_SETUP;
                        r_psel   <= 1'b1;
                        r_paddr  <= CTRL_ADDR;
                        r_pwrite <= 1'b1;
                        r_pwdata <= 32'd1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state  <= S_RD_STATUS;
                        r_phase  <= PH_SETUP;
                        r_psel   <= 1'b1;
                        r_paddr  <= STATUS_ADDR;
                        r_pwrite <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    case (r_phase)
                        PH_IDLE: begin
                            r_phase  <= PH_SETUP;
                            r_psel   <= 1'b1;
                            r_paddr  <= f_addr(r_state);
                            r_pwrite <= (r_state == S_WR_START) || (r_state == S_WR_CLEAR);
                            r_pwdata <= (r_state == S_WR_START) ? 32'd1 : 32'd0;
                        end
                        PH_SETUP: begin
                            r_phase    <= PH_ACCESS;
                            r_penable  <= 1'b1;
                            r_wait_cnt <= '0;
                        end
                        default: begin
                            if (pready_i) begin
                                r_psel    <= 1'b0;
                                r_penable <= 1'b0;
                                r_pwrite  <= 1'b0;
                                r_phase   <= PH_IDLE;
                                case (r_state)
                                    S_WR_START: begin
                                        r_state    <= S_RD_STATUS;
                                        r_poll_cnt <= '0;
                                    end
                                    S_RD_STATUS: begin
                                        if (prdata_i[0]) begin
                                            r_err   <= prdata_i[1];
                                            r_state <= S_RD_SIG;
                                        end else if (r_poll_cnt == POLL_LAST) begin
                                            r_timeout <= 1'b1;
                                            r_state   <= S_IDLE;
                                        end else begin
                                            r_poll_cnt <= r_poll_cnt + 1'b1;
                                            r_gap_cnt  <= '0;
                                            r_state    <= S_GAP;
                                        end
                                    end
                                    S_RD_SIG: begin
                                        r_last_sig <= prdata_i;
                                        r_state    <= S_WR_CLEAR;
                                    end
                                    S_WR_CLEAR: begin
                                        r_state     <= S_IDLE;
                                        r_run_count <= r_run_count + 1'b1;
                                        if (r_err) begin
                                            r_fail <= 1'b1;
                                        end else begin
                                            r_pass <= 1'b1;
                                        end
                                    end
                                    default: ;
                                endcase
                            end else if (r_wait_cnt == WAIT_LAST) begin
                                r_psel    <= 1'b0;
                                r_penable <= 1'b0;
                                r_pwrite  <= 1'b0;
                                r_phase   <= PH_IDLE;
                                r_state   <= S_IDLE;
                                r_timeout <= 1'b1;
                            end else begin
                                r_wait_cnt <= r_wait_cnt + 1'b1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    assign paddr_o     = r_paddr;
    assign psel_o      = r_psel;
    assign penable_o   = r_penable;
    assign pwrite_o    = r_pwrite;
    assign pwdata_o    = r_pwdata;
    assign busy_o      = r_busy;
    assign pass_o      = r_pass;
    assign fail_o      = r_fail;
    assign timeout_o   = r_timeout;
    assign last_sig_o  = r_last_sig;
    assign run_count_o = r_run_count;

endmodule

// File: tb/tb_bist_apb_sequencer.sv
// Bench for bist_apb_sequencer: an APB completer with random wait states logs every transfer,
// and a run-level model predicts the transfer list and result flags for each BIST run.
`timescale 1ns/1ps
module tb_bist_apb_sequencer;

    localparam int unsigned PERIOD    = 10;
    localparam int unsigned POLL_GAP  = 8;
    localparam int unsigned MAX_POLLS = 16;
    localparam int unsigned PTO       = 64;
    localparam logic [31:0] CTRL = 32'h0, STAT = 32'h4, SIGA = 32'h8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        enable_i = 1'b0;
    logic        trigger_i = 1'b0;
    logic        clear_i = 1'b0;
    logic [31:0] paddr_o;
    logic        psel_o, penable_o, pwrite_o;
    logic [31:0] pwdata_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        busy_o, pass_o, fail_o, timeout_o;
    logic [31:0] last_sig_o;
    logic [15:0] run_count_o;

    bist_apb_sequencer #(
        .PERIOD         (PERIOD),
        .POLL_GAP       (POLL_GAP),
        .MAX_POLLS      (MAX_POLLS),
        .PREADY_TIMEOUT (PTO)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .enable_i    (enable_i),
        .trigger_i   (trigger_i),
        .clear_i     (clear_i),
        .paddr_o     (paddr_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .pwdata_o    (pwdata_o),
        .prdata_i    (prdata_i),
        .pready_i    (pready_i),
        .busy_o      (busy_o),
        .pass_o      (pass_o),
        .fail_o      (fail_o),
        .timeout_o   (timeout_o),
        .last_sig_o  (last_sig_o),
        .run_count_o (run_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          gap;
    } xfer_t;

    xfer_t       log_q[$];
    xfer_t       exp_q[$];
    logic [31:0] status_q[$];
    logic [31:0] sig_val = 32'h0;
    logic [31:0] dflt_status = 32'h1;
    int          max_wait = 0;
    bit          stall = 1'b0;

    int pass_pulses = 0, access_cycles = 0, proto_errs = 0;
    int checks = 0, errors = 0;

    logic [15:0] exp_rc = '0;
    bit          exp_fail = 1'b0, exp_timeout = 1'b0;
    logic [31:0] exp_sig = '0;
    int          exp_pass = 0;

    // APB completer and protocol monitor; all sampling and driving on the falling edge.
    initial begin : completer
        bit    prev_psel, prev_done;
        int    idle_run, waits, target, stat_idx;
        xfer_t cur;
        prev_psel = 0; prev_done = 0; idle_run = 0; waits = 0; target = 0; stat_idx = 0;
        cur.addr = '0; cur.wr = 1'b0; cur.wdata = '0; cur.gap = 0;
        pready_i = 1'b0; prdata_i = '0;
        forever begin
            @(negedge clk_i);
            prdata_i = $urandom;
            pready_i = 1'b0;
            if (!rst_ni) begin
                prev_psel = 0; prev_done = 0; idle_run = 0;
            end else begin
                if (pass_o) pass_pulses++;
                if (psel_o && penable_o) access_cycles++;
                if ((penable_o && !psel_o) || (pwrite_o && !psel_o) || (prev_done && psel_o))
                    proto_errs++;
                if (psel_o && !prev_psel) begin
                    if (penable_o) proto_errs++;
                    cur.addr = paddr_o; cur.wr = pwrite_o; cur.wdata = pwdata_o; cur.gap = idle_run;
                    waits = 0;
                    target = int'($urandom_range(max_wait, 0));
                    if (pwrite_o && paddr_o == CTRL && pwdata_o == 32'd1) stat_idx = 0;
                end else if (psel_o) begin
                    if (!penable_o || paddr_o !== cur.addr || pwrite_o !== cur.wr ||
                        pwdata_o !== cur.wdata)
                        proto_errs++;
                end
                idle_run  = psel_o ? 0 : idle_run + 1;
                prev_done = 0;
                if (psel_o && penable_o && !stall) begin
                    if (waits >= target) begin
                        pready_i  = 1'b1;
                        prev_done = 1;
                        if (!cur.wr && cur.addr == STAT) begin
                            prdata_i = (stat_idx < status_q.size()) ? status_q[stat_idx] : dflt_status;
                            stat_idx++;
                        end else if (!cur.wr && cur.addr == SIGA) begin
                            prdata_i = sig_val;
                        end
                        log_q.push_back(cur);
                    end else begin
                        waits++;
                    end
                end
                prev_psel = psel_o;
            end
        end
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected transfers and result of one run, from the STATUS responses the completer will give.
    task automatic model_run();
        logic [31:0] s;
        bit          done;
        int          n;
        done = 0; n = 0; s = '0;
        exp_q.delete();
        exp_pass = 0;
        exp_q.push_back('{CTRL, 1'b1, 32'd1, 0});
        while (n < int'(MAX_POLLS) && !done) begin
            s = (n < status_q.size()) ? status_q[n] : dflt_status;
            exp_q.push_back('{STAT, 1'b0, 32'd0, (n == 0) ? 1 : int'(POLL_GAP)});
            n++;
            if (s[0]) done = 1;
        end
        if (done) begin
            exp_q.push_back('{SIGA, 1'b0, 32'd0, 1});
            exp_q.push_back('{CTRL, 1'b1, 32'd0, 1});
            exp_sig = sig_val;
            exp_rc  = exp_rc + 16'd1;
            if (s[1]) exp_fail = 1'b1;
            else      exp_pass = 1;
        end else begin
            exp_timeout = 1'b1;
        end
    endtask

    task automatic pulse_trigger();
        @(posedge clk_i); #1 trigger_i = 1'b1;
        @(posedge clk_i); #1 trigger_i = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge clk_i); #1 clear_i = 1'b1;
        @(posedge clk_i); #1 clear_i = 1'b0;
        exp_fail = 1'b0; exp_timeout = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy_o !== 1'b0 && k < 4000) begin
            @(negedge clk_i);
            k++;
        end
        check({tag, ":idle"}, 96'(k < 4000), 96'd1);
    endtask

    task automatic check_flags(input string tag);
        check({tag, ":fail"}, 96'(fail_o), 96'(exp_fail));
        check({tag, ":timeout"}, 96'(timeout_o), 96'(exp_timeout));
        check({tag, ":runs"}, 96'(run_count_o), 96'(exp_rc));
        check({tag, ":sig"}, 96'(last_sig_o), 96'(exp_sig));
    endtask

    task automatic do_run(input string tag);
        int    lb, pb, eb, n;
        xfer_t o, e;
        lb = log_q.size(); pb = pass_pulses; eb = proto_errs;
        model_run();
        pulse_trigger();
        check({tag, ":start"}, 96'({psel_o, penable_o, busy_o}), 96'(3'b101));
        wait_idle(tag);
        @(negedge clk_i);
        check({tag, ":nxfer"}, 96'(log_q.size() - lb), 96'(exp_q.size()));
        n = (log_q.size() - lb < exp_q.size()) ? log_q.size() - lb : exp_q.size();
        for (int i = 0; i < n; i++) begin
            o = log_q[lb + i];
            e = exp_q[i];
            if (i == 0) begin o.gap = 0; e.gap = 0; end
            if (!o.wr) o.wdata = '0;
            check($sformatf("%s:xfer%0d", tag, i), {o.addr, o.wr, o.wdata, 16'(o.gap)},
                  {e.addr, e.wr, e.wdata, 16'(e.gap)});
        end
        check({tag, ":pass"}, 96'(pass_pulses - pb), 96'(exp_pass));
        check({tag, ":proto"}, 96'(proto_errs - eb), 96'd0);
        check_flags(tag);
    endtask

    initial begin : stim
        int          nz, lb, pb, eb, ab, k, starts;
        bit          inj1, inj2;
        logic [15:0] base;

        repeat (3) @(posedge clk_i);
        #1;
        check("rst:apb", 96'({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o}), 96'd0);
        check("rst:status", 96'({busy_o, pass_o, fail_o, timeout_o, run_count_o, last_sig_o}), 96'd0);
        #2 rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);

        // Single pass run, zero wait states.
        status_q = {32'h1}; sig_val = 32'hDEAD_BEEF; max_wait = 0; dflt_status = 32'h1;
        do_run("t1");

        // Two not-done polls then done with error.
        status_q = {32'h0, 32'h0, 32'h3}; sig_val = $urandom; max_wait = 2;
        do_run("t2");

        // Completer never ready in the first ACCESS phase.
        stall = 1'b1;
        lb = log_q.size(); pb = pass_pulses; ab = access_cycles;
        pulse_trigger();
        wait_idle("t3");
        @(negedge clk_i);
        exp_timeout = 1'b1;
        check("t3:access", 96'(access_cycles - ab), 96'(PTO));
        check("t3:nxfer", 96'(log_q.size() - lb), 96'd0);
        check("t3:pass", 96'(pass_pulses - pb), 96'd0);
        check_flags("t3");
        pulse_clear();
        check("t3:cleared", 96'({fail_o, timeout_o}), 96'd0);
        stall = 1'b0;

        // STATUS never reports done.
        status_q.delete(); dflt_status = 32'h0; max_wait = 1;
        do_run("t6");
        pulse_clear();

        for (int r = 0; r < 12; r++) begin
            status_q.delete();
            nz = ($urandom_range(5, 0) == 0) ? int'(MAX_POLLS) + 2 : int'($urandom_range(4, 0));
            for (int z = 0; z < nz; z++) status_q.push_back($urandom & 32'hFFFF_FFFE);
            status_q.push_back($urandom | 32'h1);
            dflt_status = 32'h0; sig_val = $urandom; max_wait = int'($urandom_range(3, 0));
            if ($urandom_range(1, 0) == 1) pulse_clear();
            do_run($sformatf("rnd%0d", r));
        end

        // Periodic runs; triggers while busy must not add runs.
        status_q.delete(); dflt_status = 32'h1; max_wait = 0; sig_val = $urandom;
        lb = log_q.size(); pb = pass_pulses; eb = proto_errs; base = run_count_o;
        inj1 = 0; inj2 = 0; k = 0;
        @(negedge clk_i);
        enable_i = 1'b1;
        while (run_count_o !== base + 16'd3 && k < 2000) begin
            @(negedge clk_i);
            k++;
            trigger_i = 1'b0;
            if (!inj1 && run_count_o == base + 16'd1 && busy_o) begin
                trigger_i = 1'b1; inj1 = 1;
            end else if (inj1 && !inj2 && run_count_o == base + 16'd1 && psel_o) begin
                trigger_i = 1'b1; inj2 = 1;
            end
        end
        trigger_i = 1'b0;
        enable_i  = 1'b0;
        check("t4:done", 96'(k < 2000), 96'd1);
        wait_idle("t4");
        repeat (PERIOD + 2) @(negedge clk_i);
        exp_rc = exp_rc + 16'd3; exp_sig = sig_val;
        starts = 0;
        for (int i = lb; i < log_q.size(); i++) begin
            if (log_q[i].wr && log_q[i].addr == CTRL && log_q[i].wdata == 32'd1) begin
                if (starts > 0)
                    check($sformatf("t4:period%0d", starts), 96'(log_q[i].gap), 96'(PERIOD));
                starts++;
            end
        end
        check("t4:starts", 96'(starts), 96'd3);
        check("t4:pass", 96'(pass_pulses - pb), 96'd3);
        check("t4:proto", 96'(proto_errs - eb), 96'd0);
        check_flags("t4");

        // Asynchronous reset in the middle of an ACCESS phase.
        stall = 1'b1;
        pulse_trigger();
        k = 0;
        while (!(psel_o && penable_o) && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        check("t5:access", 96'(k < 100), 96'd1);
        repeat (3) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("t5:apb", 96'({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o}), 96'd0);
        check("t5:status", 96'({busy_o, pass_o, fail_o, timeout_o, run_count_o, last_sig_o}), 96'd0);
        exp_rc = '0; exp_fail = 1'b0; exp_timeout = 1'b0; exp_sig = '0;
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        stall = 1'b0;
        status_q = {32'h1}; sig_val = $urandom; max_wait = 1;
        do_run("t5post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
